// File: rtl/cla_serial_addsub_if.sv
// Operand/result bundle between a requester and the serial lookahead add/sub unit.
// Requester drives start/sub/a/b; the unit returns busy/done and the registered result.
interface cla_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/cla_serial_addsub.sv
// Add/sub reusing one 4-bit carry-lookahead slice per cycle, LSB nibble first; done pulses
// WIDTH/4 cycles after start is taken in IDLE, and start outside IDLE is dropped (no queueing).
module cla_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_serial_addsub_if.slave    bus
);

  localparam int GROUPS = WIDTH / 4;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [GW-1:0]    grp_q, grp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] ga, gb, p, g, s;
  logic [4:0] c;

  // One nibble of lookahead; every carry is a flat sum of products from carry_q.
  always_comb begin
    ga   = op_a_q[{grp_q, 2'b00} +: 4];
    gb   = op_b_q[{grp_q, 2'b00} +: 4];
    p    = ga ^ gb;
    g    = ga & gb;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s    = p ^ c[3:0];
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    grp_d    = grp_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
          op_a_d   = bus.a;
          op_b_d   = bus.b ^ {WIDTH{bus.sub}};
          carry_d  = bus.sub;
          grp_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[{grp_q, 2'b00} +: 4] = s;
        carry_d = c[4];
        if (grp_q == LAST_GRP) begin
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      grp_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      carry_q  <= carry_d;
      grp_q    <= grp_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Bench for cla_serial_addsub at WIDTH=16 and WIDTH=8: directed vectors, handshake and
// reset corners, then random operands scored against an arithmetic reference model.
module tb_cla_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_serial_addsub_if #(.WIDTH(16)) bus16 ();
  cla_serial_addsub_if #(.WIDTH(8))  bus8 ();

  cla_serial_addsub #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cla_serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Expected {ovf, cout, result[15:0]}, pushed at drive time, popped on done.
  logic [17:0] exp16_q[$];
  logic [17:0] exp8_q[$];

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] model(input int w, input logic s,
                                        input logic [15:0] x, input logic [15:0] y);
    logic [31:0] mask, bb, sum;
    logic        co, cm;
    mask = (32'd1 << w) - 32'd1;
    bb   = (s ? ~{16'h0, y} : {16'h0, y}) & mask;
    sum  = ({16'h0, x} & mask) + bb + {31'h0, s};
    co   = sum[w];
    cm   = x[w-1] ^ bb[w-1] ^ sum[w-1];
    return {cm ^ co, co, sum[15:0] & mask[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus16.done) begin
      if (exp16_q.size() == 0) begin
        chk("unexpected_done16", 32'd1, 32'd0);
      end else begin
        chk("res16", {14'h0, bus16.ovf, bus16.cout, bus16.result}, {14'h0, exp16_q.pop_front()});
      end
    end
    if (rst_n && bus8.done) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        chk("res8", {14'h0, bus8.ovf, bus8.cout, 8'h0, bus8.result}, {14'h0, exp8_q.pop_front()});
      end
    end
  end

  // Issues one operation; returns cycles from the start edge to done and busy cycles seen.
  task automatic op16(input logic s, input logic [15:0] x, input logic [15:0] y,
                      input logic [17:0] e, output int lat, output int bcnt);
    int n;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.sub   = s;
    bus16.a     = x;
    bus16.b     = y;
    exp16_q.push_back(e);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = ~x;
    bus16.b     = ~y;
    bus16.sub   = ~s;
    n = 1;
    bcnt = 0;
    while (!bus16.done && n < 20) begin
      if (bus16.busy) bcnt++;
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    if (!bus16.done) chk("timeout16", 32'd0, 32'd1);
  endtask

  task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y, output int lat);
    int n;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.sub   = s;
    bus8.a     = x;
    bus8.b     = y;
    exp8_q.push_back(model(8, s, {8'h0, x}, {8'h0, y}));
    @(negedge clk);
    bus8.start = 1'b0;
    n = 1;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    if (!bus8.done) chk("timeout8", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat, bcnt, t1, t2, dcnt;
    logic s;
    logic [15:0] x, y;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.a  = '0; bus8.b  = '0;

    repeat (3) @(negedge clk);
    chk("reset_outs16", {27'h0, bus16.busy, bus16.done, bus16.cout, bus16.ovf, |bus16.result}, 32'd0);
    chk("reset_outs8", {27'h0, bus8.busy, bus8.done, bus8.cout, bus8.ovf, |bus8.result}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op16(vecs[i].sub, vecs[i].a, vecs[i].b, {vecs[i].ovf, vecs[i].cout, vecs[i].res}, lat, bcnt);
      chk("lat16", lat, 4);
      chk("busy16", bcnt, 4);
    end

    // start held high with operands changing mid-run: second op starts in first IDLE cycle.
    @(negedge clk);
    bus16.start = 1'b1; bus16.sub = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h4321;
    exp16_q.push_back({1'b0, 1'b0, 16'h5555});
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'h0001;
    exp16_q.push_back({1'b0, 1'b1, 16'h0000});
    dcnt = 0;
    while (!bus16.done && dcnt < 20) begin @(negedge clk); dcnt++; end
    t1 = cyc;
    @(negedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    dcnt = 0;
    while (!bus16.done && dcnt < 20) begin @(negedge clk); dcnt++; end
    t2 = cyc;
    chk("b2b_period", t2 - t1, 6);

    // Reset while group 2 is pending: partial result must vanish, no done.
    @(negedge clk);
    bus16.start = 1'b1; bus16.sub = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h4321;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial16", bus16.result, 16'h0055);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst", {27'h0, bus16.busy, bus16.done, bus16.cout, bus16.ovf, |bus16.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus16.done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);
    op16(1'b1, 16'h0007, 16'h0005, {1'b0, 1'b1, 16'h0002}, lat, bcnt);
    chk("lat16_after_rst", lat, 4);

    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom());
      y = 16'($urandom());
      op16(s, x, y, model(16, s, x, y), lat, bcnt);
      if (lat != 4) chk("lat16_rand", lat, 4);
    end

    op8(1'b0, 8'hFF, 8'h01, lat);
    chk("lat8", lat, 2);
    for (int i = 0; i < 1000; i++) begin
      op8(1'($urandom_range(0, 1)), 8'($urandom()), 8'($urandom()), lat);
      if (lat != 2) chk("lat8_rand", lat, 2);
    end

    @(negedge clk);
    chk("sb16_empty", exp16_q.size(), 0);
    chk("sb8_empty", exp8_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
